// File: rtl/pattern_bcd_counter.sv
// Serial pattern detector with a two-digit BCD match count and a digit-scan select
// for the downstream 2:1 display mux (ones -> a, tens -> b, digit_sel -> sel).
module pattern_bcd_counter #(
    parameter logic [3:0]  PATTERN  = 4'b1011,
    parameter int unsigned SCAN_DIV = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       bit_valid,
    input  logic       bit_in,
    input  logic       clear,
    output logic       match,
    output logic [3:0] ones_digit,
    output logic [3:0] tens_digit,
    output logic       digit_sel,
    output logic       overflow
);

    localparam int unsigned ScanW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [ScanW-1:0] ScanMax = ScanW'(SCAN_DIV - 1);

    logic [3:0]       history_q, history_d;
    logic [2:0]       fill_q, fill_d;
    logic             match_q, match_d;
    logic [3:0]       ones_q, ones_d;
    logic [3:0]       tens_q, tens_d;
    logic             ovf_q, ovf_d;
    logic             sel_q, sel_d;
    logic [ScanW-1:0] scan_q, scan_d;

    logic             accept;
    logic [3:0]       shifted;
    logic             hit;

    // fill gate keeps the zeroed history from producing early matches
    always_comb begin
        accept  = bit_valid & ~clear;
        shifted = {history_q[2:0], bit_in};
        hit     = accept && (fill_q >= 3'd3) && (shifted == PATTERN);
    end

    always_comb begin
        history_d = history_q;
        fill_d    = fill_q;
        match_d   = 1'b0;
        ones_d    = ones_q;
        tens_d    = tens_q;
        ovf_d     = ovf_q;
        if (clear) begin
            history_d = 4'd0;
            fill_d    = 3'd0;
            ones_d    = 4'd0;
            tens_d    = 4'd0;
            ovf_d     = 1'b0;
        end else if (accept) begin
            history_d = shifted;
            if (fill_q != 3'd4) begin
                fill_d = fill_q + 3'd1;
            end
            if (hit) begin
                match_d = 1'b1;
                if (ones_q != 4'd9) begin
                    ones_d = ones_q + 4'd1;
                end else if (tens_q != 4'd9) begin
                    ones_d = 4'd0;
                    tens_d = tens_q + 4'd1;
                end else begin
                    ones_d = 4'd0;
                    tens_d = 4'd0;
                    ovf_d  = 1'b1;
                end
            end
        end
    end

    // Scan generator free-runs; clear and bit_valid never touch it
    always_comb begin
        scan_d = scan_q;
        sel_d  = sel_q;
        if (scan_q == ScanMax) begin
            scan_d = '0;
            sel_d  = ~sel_q;
        end else begin
            scan_d = scan_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            history_q <= 4'd0;
            fill_q    <= 3'd0;
            match_q   <= 1'b0;
            ones_q    <= 4'd0;
            tens_q    <= 4'd0;
            ovf_q     <= 1'b0;
            sel_q     <= 1'b0;
            scan_q    <= '0;
        end else begin
            history_q <= history_d;
            fill_q    <= fill_d;
            match_q   <= match_d;
            ones_q    <= ones_d;
            tens_q    <= tens_d;
            ovf_q     <= ovf_d;
            sel_q     <= sel_d;
            scan_q    <= scan_d;
        end
    end

    assign match      = match_q;
    assign ones_digit = ones_q;
    assign tens_digit = tens_q;
    assign digit_sel  = sel_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_pattern_bcd_counter.sv
// Scoreboard bench: stimulus pushes expected match records, a negedge monitor pops
// them on each match pulse; a second instance covers PATTERN=0000 and SCAN_DIV=3.
module tb_pattern_bcd_counter;

    typedef struct {
        int unsigned cyc;
        logic [3:0]  ones;
        logic [3:0]  tens;
        logic        ovf;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       bva = 1'b0, bia = 1'b0, clr_a = 1'b0;
    logic       bvb = 1'b0, bib = 1'b0, clr_b = 1'b0;
    logic       match_a, sel_a, ovf_a;
    logic [3:0] ones_a, tens_a;
    logic       match_b, sel_b, ovf_b;
    logic [3:0] ones_b, tens_b;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    int unsigned cyc = 0;
    int unsigned k = 0;
    bit          mon_en = 1'b0;
    exp_t        qa[$];
    exp_t        qb[$];
    exp_t        ea, eb;

    pattern_bcd_counter #(.PATTERN(4'b1011), .SCAN_DIV(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .bit_valid(bva), .bit_in(bia), .clear(clr_a),
        .match(match_a), .ones_digit(ones_a), .tens_digit(tens_a),
        .digit_sel(sel_a), .overflow(ovf_a)
    );

    pattern_bcd_counter #(.PATTERN(4'b0000), .SCAN_DIV(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .bit_valid(bvb), .bit_in(bib), .clear(clr_b),
        .match(match_b), .ones_digit(ones_b), .tens_digit(tens_b),
        .digit_sel(sel_b), .overflow(ovf_b)
    );

    always #5 clk = ~clk;

    // cyc counts edges; k counts edges since reset release for the scan model
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst_n) k <= 0;
        else        k <= k + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (match_a) begin
                if (qa.size() == 0) begin
                    check("a_unexpected_match", 1, 0);
                end else begin
                    ea = qa.pop_front();
                    check("a_match_cycle", cyc, ea.cyc);
                    check("a_ones", ones_a, ea.ones);
                    check("a_tens", tens_a, ea.tens);
                    check("a_overflow", ovf_a, ea.ovf);
                end
            end else if (qa.size() != 0 && qa[0].cyc <= cyc) begin
                check("a_missing_match", 0, 1);
                ea = qa.pop_front();
            end
            if (match_b) begin
                if (qb.size() == 0) begin
                    check("b_unexpected_match", 1, 0);
                end else begin
                    eb = qb.pop_front();
                    check("b_match_cycle", cyc, eb.cyc);
                    check("b_ones", ones_b, eb.ones);
                    check("b_tens", tens_b, eb.tens);
                    check("b_overflow", ovf_b, eb.ovf);
                end
            end else if (qb.size() != 0 && qb[0].cyc <= cyc) begin
                check("b_missing_match", 0, 1);
                eb = qb.pop_front();
            end
            check("a_digit_sel", sel_a, (k / 4) % 2);
            check("b_digit_sel", sel_b, (k / 3) % 2);
        end
    end

    task automatic send(input bit inst, input logic b, input bit hit,
                        input int e_ones, input int e_tens, input bit e_ovf);
        exp_t e;
        @(negedge clk);
        if (inst == 1'b0) begin
            bva = 1'b1; bia = b; bvb = 1'b0;
        end else begin
            bvb = 1'b1; bib = b; bva = 1'b0;
        end
        if (hit) begin
            e.cyc  = cyc + 1;
            e.ones = 4'(e_ones);
            e.tens = 4'(e_tens);
            e.ovf  = e_ovf;
            if (inst == 1'b0) qa.push_back(e);
            else              qb.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        bva = 1'b0;
        bvb = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst_n = 1'b0; bva = 1'b0; bvb = 1'b0; clr_a = 1'b0;
        repeat (n) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic check_a(input string tag, input int o, input int t, input bit v);
        check({tag, "_match"}, match_a, 0);
        check({tag, "_ones"}, ones_a, o);
        check({tag, "_tens"}, tens_a, t);
        check({tag, "_overflow"}, ovf_a, v);
    endtask

    initial begin
        // Reset and idle scan
        do_reset(3);
        mon_en = 1'b1;
        check_a("reset", 0, 0, 0);
        idle(20);
        check_a("idle", 0, 0, 0);

        // Overlapping matches: 1,0,1,1,0,1,1
        send(0, 1, 0, 0, 0, 0);
        send(0, 0, 0, 0, 0, 0);
        send(0, 1, 0, 0, 0, 0);
        send(0, 1, 1, 1, 0, 0);
        send(0, 0, 0, 0, 0, 0);
        send(0, 1, 0, 0, 0, 0);
        send(0, 1, 1, 2, 0, 0);
        idle(3);
        check_a("overlap", 2, 0, 0);

        // Gapped stream, then a non-matching stream
        do_reset(1);
        send(0, 1, 0, 0, 0, 0); idle(2);
        send(0, 0, 0, 0, 0, 0); idle(1);
        send(0, 1, 0, 0, 0, 0); idle(3);
        send(0, 1, 1, 1, 0, 0); idle(2);
        send(0, 1, 0, 0, 0, 0);
        send(0, 1, 0, 0, 0, 0);
        send(0, 1, 0, 0, 0, 0);
        send(0, 1, 0, 0, 0, 0);
        send(0, 0, 0, 0, 0, 0);
        send(0, 0, 0, 0, 0, 0);
        send(0, 0, 0, 0, 0, 0);
        idle(2);
        check_a("nomatch", 1, 0, 0);

        // PATTERN=0000 needs four accepted zeros before the first match
        send(1, 0, 0, 0, 0, 0);
        send(1, 0, 0, 0, 0, 0);
        send(1, 0, 0, 0, 0, 0);
        send(1, 0, 1, 1, 0, 0);
        send(1, 0, 1, 2, 0, 0);
        idle(2);
        check("b_ones_final", ones_b, 2);

        // Clear, then wrap through 99 -> 00 and one beyond
        @(negedge clk);
        clr_a = 1'b1; bva = 1'b0;
        @(negedge clk);
        clr_a = 1'b0;
        check_a("clear0", 0, 0, 0);
        for (int i = 1; i <= 101; i++) begin
            send(0, 1, 0, 0, 0, 0);
            send(0, 0, 0, 0, 0, 0);
            send(0, 1, 0, 0, 0, 0);
            send(0, 1, 1, i % 10, (i / 10) % 10, i >= 100);
        end
        idle(2);
        check_a("wrap", 1, 0, 1);

        // Clear colliding with a completing bit; history must restart
        send(0, 1, 0, 0, 0, 0);
        send(0, 0, 0, 0, 0, 0);
        send(0, 1, 0, 0, 0, 0);
        @(negedge clk);
        clr_a = 1'b1; bva = 1'b1; bia = 1'b1;
        @(negedge clk);
        clr_a = 1'b0; bva = 1'b0;
        check_a("clear_collide", 0, 0, 0);
        send(0, 1, 0, 0, 0, 0);
        send(0, 0, 0, 0, 0, 0);
        send(0, 1, 0, 0, 0, 0);
        send(0, 1, 1, 1, 0, 0);
        idle(5);

        // Reset lands on the edge that would complete a match
        send(0, 1, 0, 0, 0, 0);
        send(0, 0, 0, 0, 0, 0);
        send(0, 1, 0, 0, 0, 0);
        @(negedge clk);
        bva = 1'b1; bia = 1'b1; rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; bva = 1'b0;
        check_a("reset_mid", 0, 0, 0);
        check("reset_mid_sel", sel_a, 0);
        idle(12);

        check("a_pending", qa.size(), 0);
        check("b_pending", qb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pattern_bcd_counter.md
Name: pattern_bcd_counter

Overview:
Upstream feeder of the 4-bit 2:1 display mux in the PatternCounter design. Accepts a serial bit stream and detects a 4-bit pattern, with overlapping matches counted. Keeps a two-digit BCD match count. Generates the digit-scan select that drives the mux: `ones_digit` goes to mux input a, `tens_digit` to mux input b, and `digit_sel` to sel.

Parameters:
PATTERN, 4'b1011, pattern to detect; the MSB is the oldest bit received.
SCAN_DIV, 16, clock cycles per digit-scan phase; legal range 2..65535.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst_n  input  1  synchronous reset, active-low
bit_valid  input  1  qualifies bit_in for this cycle
bit_in  input  1  serial data bit
clear  input  1  synchronous count/history clear, active-high
match  output  1  one-cycle pulse per detected pattern
ones_digit  output  4  BCD ones digit of match count (0..9)
tens_digit  output  4  BCD tens digit of match count (0..9)
digit_sel  output  1  scan select: 0 = ones phase, 1 = tens phase
overflow  output  1  sticky; set when count wraps 99->00

Behaviour:
- Reset: one clock; synchronous, active-low. While rst_n=0 at a rising edge, every register clears:
  - history=0, fill=0, match=0;
  - ones_digit=0, tens_digit=0, overflow=0;
  - digit_sel=0, scan counter=0.
  - rst_n has priority over all other inputs.
- History register:
  - 4-bit shift register. On each accepted bit, history <= {history[2:0], bit_in}.
  - Accepted bit: bit_valid=1, clear=0, rst_n=1.
  - fill is a 0..4 saturating counter of accepted bits since reset/clear.
- Detection:
  - A match occurs on an accepted bit when fill>=3 before the shift and {history[2:0], bit_in} == PATTERN.
  - The fill requirement stops zero-initialised history from matching early, e.g. for PATTERN=4'b0000 or 4'b0001.
  - Overlapping matches count; the history is not flushed after a match.
- match timing:
  - match is registered. It is high for exactly the cycle after the edge that accepted the completing bit.
  - Otherwise match=0, including cycles with bit_valid=0.
- Counter timing: ones_digit/tens_digit update on the same edge that sets match. The new count is visible together with the match pulse.
- BCD increment:
  - ones<9: ones+1.
  - ones=9, tens<9: ones=0, tens+1.
  - ones=9, tens=9: both 0, overflow<=1.
  - overflow stays set until reset or clear.
- clear=1 at an edge:
  - Sets history=0, fill=0, count=00, overflow=0, match=0.
  - A simultaneous bit_valid is discarded.
  - The scan counter and digit_sel are unaffected.
- Scan generator:
  - Free-running counter 0..SCAN_DIV-1, width $clog2(SCAN_DIV).
  - When the counter equals SCAN_DIV-1 it wraps to 0 and digit_sel toggles.
  - First toggle happens SCAN_DIV cycles after reset release.
  - The scan generator is independent of bit_valid and clear.
- Combinational paths: none from inputs to outputs; all outputs are direct register outputs.
- Idle: with bit_valid=0, all state holds except the scan logic.

Test Plan:
1. Reset/idle: hold rst_n=0 for 3 cycles, release, then 20 idle cycles with SCAN_DIV=4 -> match=0, digits 0/0, overflow=0; digit_sel toggles at 4, 8, 12 ... cycles after release.
2. Overlap: stream 1,0,1,1,0,1,1 (bit_valid=1 every cycle) -> match pulses the cycle after bit 4 and after bit 7; count 01 then 02; no pulse on other cycles.
3. Gapped/non-match: stream 1,0,1,1 with bit_valid=0 gaps between bits -> single match, count 01. Stream 1,1,1,1,0,0,0 -> no match. PATTERN=4'b0000 with 3 zeros after reset -> no match; 4th zero -> match.
4. Wrap: drive 99 matches -> ones=9, tens=9, overflow=0; 100th match -> 0/0, overflow=1; next match -> 1/0, overflow stays 1.
5. Clear collision: after 1,0,1, assert clear together with bit_valid=1, bit_in=1 -> no match, count 00, overflow 0, fill 0; a following 1,0,1,1 is needed to match; digit_sel phase unchanged by clear.
6. Reset mid-operation: pull rst_n=0 on the cycle a match would complete -> next cycle match=0, count 00, digit_sel=0, scan counter 0.
